uart_rx_merge: RTL

- Sits directly downstream of multi_uart_top's receive side and consumes its per-channel byte pulses (rx_data_chN / rx_done_chN, N = 0, 1).
- Buffers each channel's bytes in its own FIFO.
- Merges both FIFOs into a single valid/ready byte stream, tagged with the source channel, using round-robin arbitration.
- Flags bytes dropped on FIFO overflow with sticky overrun bits, so software or a downstream consumer can stall without silent loss.

---
 rtl/uart_rx_merge.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_merge.sv
// Two-channel UART receive merger: per-channel byte FIFOs feeding one
// valid/ready output register, round-robin arbitrated, with sticky overrun flags.

module uart_rx_merge_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic                     ovr_clr,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     ovr
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              full, push, pop;

    // Fullness is judged on the pre-edge count, so a same-edge pop never
    // makes room for the incoming byte.
    assign full    = (level == FULL_CNT);
    assign empty   = (level == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovr    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (wr_en && full) ovr <= 1'b1;
            else if (ovr_clr)  ovr <= 1'b0;
        end
    end
endmodule

module uart_rx_merge #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      rx_data_ch0,
    input  logic                   rx_done_ch0,
    input  logic [DATA_W-1:0]      rx_data_ch1,
    input  logic                   rx_done_ch1,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_W-1:0]      m_data,
    output logic                   m_chan,
    output logic                   ovr_ch0,
    output logic                   ovr_ch1,
    input  logic                   ovr_clr,
    output logic [$clog2(DEPTH):0] level_ch0,
    output logic [$clog2(DEPTH):0] level_ch1
);
    localparam int NUM_CH = 2;
    localparam int AW     = $clog2(DEPTH);

    typedef struct packed {
        logic              chan;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic [NUM_CH-1:0][DATA_W-1:0] wr_data, rd_data;
    logic [NUM_CH-1:0]             wr_en, rd_en, empty, ovr;
    logic [NUM_CH-1:0][AW:0]       level;

    beat_t out_q;
    logic  prio;      // 0: channel 0 wins a tie, 1: channel 1 wins
    logic  slot_free, pop, gnt;

    assign wr_data   = {rx_data_ch1, rx_data_ch0};
    assign wr_en     = {rx_done_ch1, rx_done_ch0};

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            uart_rx_merge_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .wr_en   (wr_en[g]),
                .wr_data (wr_data[g]),
                .rd_en   (rd_en[g]),
                .ovr_clr (ovr_clr),
                .rd_data (rd_data[g]),
                .level   (level[g]),
                .empty   (empty[g]),
                .ovr     (ovr[g])
            );
        end
    endgenerate

    always_comb begin
        slot_free = !m_valid || m_ready;
        pop       = slot_free && (empty != 2'b11);
        gnt       = !empty[1] && (empty[0] || prio);
        rd_en     = '0;
        if (pop) rd_en[gnt] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            out_q   <= '0;
            prio    <= 1'b0;
        end else if (slot_free) begin
            m_valid <= pop;
            if (pop) begin
                out_q <= '{chan: gnt, data: rd_data[gnt]};
                prio  <= !gnt;
            end
        end
    end

    assign m_data    = out_q.data;
    assign m_chan    = out_q.chan;
    assign ovr_ch0   = ovr[0];
    assign ovr_ch1   = ovr[1];
    assign level_ch0 = level[0];
    assign level_ch1 = level[1];
endmodule
